// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0040_0000;
  localparam logic [31:0] INSTR_NOP          = 32'h0000_0000;
  localparam logic [31:0] INSTR_EXIT_SYSCALL = 32'h0000_000C;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with +4 incrementer and word-aligned redirect.
// addr_err is combinational and flags a misaligned redirect in the cycle it is taken.
module fetch_pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        addr_err
);

  logic [31:0] pc_reg;
  logic [31:0] pc_next;

  // Wraps naturally from 32'hFFFF_FFFC to 0.
  assign pc_plus4 = pc_reg + 32'd4;
  assign addr_err = redirect && (redirect_pc[1:0] != 2'b00);
  assign pc       = pc_reg;

  always_comb begin
    pc_next = pc_reg;
    if (redirect) begin
      pc_next = align_word(redirect_pc);
    end else if (advance) begin
      pc_next = pc_plus4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: BOOT/RUN/HALT control and the IF/ID pipeline register.
// Build option: define FETCH_DELAY_SLOT_EN to keep the delay-slot instruction on a redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  input  logic [31:0] imem_instr,
  output logic [31:0] imem_addr,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic        halted,
  output logic        addr_err
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic         pc_advance;
  logic         pc_redirect;
  logic         ifid_load;
  logic         ifid_kill;
  logic         ifid_valid_reg;
  logic [31:0]  ifid_instr_reg;
  logic [31:0]  ifid_pc_reg;
  logic [31:0]  ifid_pc_plus4_reg;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk         (clk),
    .rst         (rst),
    .advance     (pc_advance),
    .redirect    (pc_redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .addr_err    (addr_err)
  );

  always_comb begin
    state_next  = state_reg;
    pc_advance  = 1'b0;
    pc_redirect = 1'b0;
    ifid_load   = 1'b0;
    ifid_kill   = 1'b0;
    case (state_reg)
      // The boot cycle is a plain fetch of RESET_PC; control inputs are not yet honoured.
      ST_BOOT: begin
        state_next = ST_RUN;
        pc_advance = 1'b1;
        ifid_load  = 1'b1;
      end
      ST_RUN: begin
        if (halt_req) begin
          state_next = ST_HALT;
          ifid_kill  = 1'b1;
        end else if (redirect_valid) begin
          pc_redirect = 1'b1;
`ifdef FETCH_DELAY_SLOT_EN
          ifid_load   = !flush;
          ifid_kill   = flush;
`else
          ifid_kill   = 1'b1;
`endif
        end else if (flush) begin
          ifid_kill  = 1'b1;
          pc_advance = !stall;
        end else if (!stall) begin
          pc_advance = 1'b1;
          ifid_load  = 1'b1;
        end
      end
      ST_HALT: begin
        ifid_kill = 1'b1;
      end
      default: begin
        state_next = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_BOOT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Payload fields hold while invalid; only the valid bit is cleared on a kill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_valid_reg    <= 1'b0;
      ifid_instr_reg    <= INSTR_NOP;
      ifid_pc_reg       <= 32'h0;
      ifid_pc_plus4_reg <= 32'h0;
    end else if (ifid_load) begin
      ifid_valid_reg    <= 1'b1;
      ifid_instr_reg    <= imem_instr;
      ifid_pc_reg       <= pc;
      ifid_pc_plus4_reg <= pc_plus4;
    end else if (ifid_kill) begin
      ifid_valid_reg    <= 1'b0;
    end
  end

  assign imem_addr     = pc;
  assign ifid_valid    = ifid_valid_reg;
  assign ifid_instr    = ifid_instr_reg;
  assign ifid_pc       = ifid_pc_reg;
  assign ifid_pc_plus4 = ifid_pc_plus4_reg;
  assign halted        = (state_reg == ST_HALT);

endmodule
